axi_interconnect_crossbar_arbit_lock: RTL

- Sequential grant controller that sits around the crossbar's combinational round-robin (polling) arbiter.
- Drives the arbiter's priority pointer (last_user) and samples its result (current_user).
- Locks the chosen slave-port user (master) for one full transaction: address handshake plus end-of-transaction (W last beat or R last beat).
- Releases the lock afterwards and advances the pointer, giving fair round-robin ownership of one crossbar output channel.

---
 rtl/axi_interconnect_crossbar_arbit_lock.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/axi_interconnect_crossbar_arbit_lock.sv
// ----------------------------------------------------------------------------
// axi_interconnect_crossbar_arbit_lock
//
// Sequential grant controller wrapped around the crossbar's combinational
// round-robin (polling) arbiter. It feeds the arbiter its priority pointer,
// captures the arbiter's pick, and locks that user onto one crossbar output
// channel until the transaction is complete: the address handshake has been
// seen and the last data beat (W or R) has been handshaken, in either order.
// On release the pointer moves to the user after the one just served.
//
// Ports:
//   clk              rising-edge clock
//   rst              asynchronous, active-high reset
//   user_req         [NUM]   per-user AxVALID requests
//   arb_current_user [WIDTH] arbiter result for user_req / arb_last_user
//   arb_last_user    [WIDTH] registered priority pointer to the arbiter
//   addr_hs                  address handshake of the granted user
//   xfer_done                last-beat handshake of the granted transaction
//   grant_valid              lock active
//   grant_user       [WIDTH] locked user index
//   grant_onehot     [NUM]   one-hot grant_user, zero when not locked
//   addr_en                  address phase enable (lock taken, no AxHS yet)
// ----------------------------------------------------------------------------
module axi_interconnect_crossbar_arbit_lock #(
    parameter int NUM   = 4,
    // Smallest n >= 1 with 2**n - 1 >= NUM - 1, i.e. clog2(NUM) for NUM >= 2.
    parameter int WIDTH = $clog2(NUM)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NUM-1:0]   user_req,
    input  logic [WIDTH-1:0] arb_current_user,
    output logic [WIDTH-1:0] arb_last_user,
    input  logic             addr_hs,
    input  logic             xfer_done,
    output logic             grant_valid,
    output logic [WIDTH-1:0] grant_user,
    output logic [NUM-1:0]   grant_onehot,
    output logic             addr_en
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_BUSY
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0] user_q, user_d;
    logic             valid_q, valid_d;
    logic             addr_en_q, addr_en_d;
    logic             done_seen_q, done_seen_d;
    logic             release_lock;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            user_q      <= '0;
            valid_q     <= 1'b0;
            addr_en_q   <= 1'b0;
            done_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            user_q      <= user_d;
            valid_q     <= valid_d;
            addr_en_q   <= addr_en_d;
            done_seen_q <= done_seen_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        user_d       = user_q;
        valid_d      = valid_q;
        addr_en_d    = addr_en_q;
        done_seen_d  = done_seen_q;
        release_lock = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (|user_req) begin
                    state_d   = S_GRANT;
                    user_d    = arb_current_user;
                    valid_d   = 1'b1;
                    addr_en_d = 1'b1;
                end
            end
            S_GRANT: begin
                if (addr_hs) begin
                    if (xfer_done || done_seen_q) begin
                        release_lock = 1'b1;
                    end else begin
                        state_d   = S_BUSY;
                        addr_en_d = 1'b0;
                    end
                end else if (xfer_done) begin
                    // Last data beat may precede the address handshake.
                    done_seen_d = 1'b1;
                end
            end
            S_BUSY: begin
                if (xfer_done) begin
                    release_lock = 1'b1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                valid_d   = 1'b0;
                addr_en_d = 1'b0;
            end
        endcase

        // Single release path: drop the lock and advance the pointer past
        // the user just served, wrapping at NUM.
        if (release_lock) begin
            state_d     = S_IDLE;
            valid_d     = 1'b0;
            addr_en_d   = 1'b0;
            done_seen_d = 1'b0;
            ptr_d       = (user_q == WIDTH'(NUM - 1)) ? '0 : user_q + WIDTH'(1);
        end
    end

    always_comb begin
        grant_onehot = '0;
        for (int unsigned i = 0; i < NUM; i++) begin
            grant_onehot[i] = valid_q && (user_q == WIDTH'(i));
        end
    end

    assign arb_last_user = ptr_q;
    assign grant_valid   = valid_q;
    assign grant_user    = user_q;
    assign addr_en       = addr_en_q;

endmodule
